snake_dir_queue: RTL and testbench
==================================

Name: snake_dir_queue

Overview:
Parametrised successor to the snake direction controller. Debounces the four raw direction buttons and turns each press into a single event. Validated turn requests go into a small FIFO, and one queued turn is applied to the snake's heading per move_tick, so quick double-turns between moves are kept rather than lost. Sits between the board button inputs and the snake movement/collision logic.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed before the debounced level changes (>=1)
QUEUE_DEPTH, 2, number of pending turns held (>=1)
INIT_DIR, 2'b00, heading loaded on reset (00 UP, 01 DOWN, 10 LEFT, 11 RIGHT)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low; 0 sampled on a clk edge resets the block
up  input  1  raw asynchronous button
down  input  1  raw asynchronous button
left  input  1  raw asynchronous button
right  input  1  raw asynchronous button
move_tick  input  1  one-cycle pulse, snake advances one cell
direction  output  2  current applied heading
queue_count  output  $clog2(QUEUE_DEPTH+1)  pending turns
queue_full  output  1  queue_count == QUEUE_DEPTH
turn_applied  output  1  one-cycle pulse, a turn was popped into direction
turn_rejected  output  1  one-cycle pulse, a press event was discarded

Behaviour:
- Reset (reset=0 at an edge):
  - direction=INIT_DIR; queue emptied (queue_count=0, queue_full=0); turn_applied=0, turn_rejected=0.
  - Synchronisers, debounce counters and debounced levels cleared to 0.
  - Reset mid-operation flushes all pending turns.
  - A button held through reset release produces one press event after debounce.
- Per-button input path:
  - 2-flop synchroniser.
  - Debounce counter: counts while the synchronised level differs from the debounced level, clears otherwise. On reaching DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - Press event = debounced rising edge, one cycle.
  - Latency: a clean press first sampled high at edge E gives its event in the cycle after edge E+1+DEBOUNCE_CYCLES. A pulse shorter than DEBOUNCE_CYCLES gives no event.
- Simultaneous press events in one cycle:
  - Priority up > down > left > right.
  - Only the winner is evaluated; losers are discarded silently (no turn_rejected from losers).
- Validation of the winning request R:
  - ref = newest queued entry if queue non-empty, else direction.
  - Reject if R == ref (duplicate).
  - Reject if R is the reverse of ref, i.e. R[1]==ref[1] and R!=ref.
  - Reject if the queue is full and no pop happens this cycle.
  - Otherwise push R.
  - A rejection pulses turn_rejected on the next cycle; nothing else changes.
- move_tick:
  - Queue non-empty: pop oldest entry into direction at that edge and pulse turn_applied the following cycle.
  - Queue empty: direction holds, no pulse.
- Simultaneous push and pop in one cycle:
  - Both take effect; queue_count is unchanged.
  - Push into a full queue is allowed when a pop occurs in the same cycle.
  - Validation uses the pre-pop ref.
  - No bypass: a push into an empty queue during a tick is applied at the next tick, not this one.
- queue_count and queue_full are registered and consistent with queue contents after every edge. They never exceed QUEUE_DEPTH or underflow.

Test Plan:
1. Hold reset=0 for 2 edges, release -> direction=00, queue_count=0, queue_full=0, no pulses.
2. From UP, hold down for 10 cycles, no tick -> single turn_rejected pulse at the latency above; direction stays 00, queue_count 0. Then right held 3 cycles -> no event, no pulse.
3. From UP, press right then down (each held 8 cycles, gap 8), no tick -> queue_count=2, queue_full=1, direction=00. First tick -> direction=11, turn_applied, count=1. Second tick -> direction=01, count=0. Third tick -> no change, no pulse.
4. Queue [right, down] full, press left with no tick -> turn_rejected, count stays 2. Repeat with left's press event coinciding with move_tick -> accepted; direction=11, queue [down, left], count 2.
5. Direction LEFT, empty queue; up and right press events in the same cycle -> up pushed (count 1), no turn_rejected. Next tick -> direction=00.
6. Queue holding 2 entries, assert reset=0 for one edge -> direction=INIT_DIR, queue_count=0. A later tick does not change direction.

Source files
------------

// File: rtl/snake_dir_queue.sv
`default_nettype none
// ============================================================================
// Module   : snake_dir_queue
// Purpose  : Debounces the four raw direction buttons, turns each debounced
//            press into a one-cycle event, validates the winning request
//            against the newest pending heading and queues it. One queued turn
//            is applied to the snake heading per move_tick, so fast
//            double-turns between moves are kept.
// Ports    : clk           - system clock, rising edge
//            reset         - synchronous, active-low reset
//            up/down/left/right - raw asynchronous buttons
//            move_tick     - one-cycle pulse, snake advances one cell
//            direction     - current applied heading (00 U, 01 D, 10 L, 11 R)
//            queue_count   - number of pending turns
//            queue_full    - queue_count == QUEUE_DEPTH
//            turn_applied  - one-cycle pulse, a turn was popped into direction
//            turn_rejected - one-cycle pulse, a press event was discarded
// Revision : 1.0 - initial release
// ============================================================================
module snake_dir_queue #(
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter int         QUEUE_DEPTH     = 2,
  parameter logic [1:0] INIT_DIR        = 2'b00
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             up,
  input  logic                             down,
  input  logic                             left,
  input  logic                             right,
  input  logic                             move_tick,
  output logic [1:0]                       direction,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count,
  output logic                             queue_full,
  output logic                             turn_applied,
  output logic                             turn_rejected
);

  localparam int c_CW  = $clog2(QUEUE_DEPTH + 1);
  localparam int c_DBW = $clog2(DEBOUNCE_CYCLES + 1);

  // Button index doubles as the requested heading code: up=00 ... right=11.
  logic [3:0] w_raw;
  logic [3:0] w_press;

  assign w_raw = {right, left, down, up};

  // --------------------------------------------------------------------------
  // Per-button synchroniser, debouncer and rising-edge detector
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             deb_prev_q;
    logic [c_DBW-1:0] cnt_q;

    always_ff @(posedge clk) begin
      if (!reset) begin
        sync1_q    <= 1'b0;
        sync2_q    <= 1'b0;
        deb_q      <= 1'b0;
        deb_prev_q <= 1'b0;
        cnt_q      <= '0;
      end else begin
        sync1_q    <= w_raw[gi];
        sync2_q    <= sync1_q;
        deb_prev_q <= deb_q;
        if (sync2_q != deb_q) begin
          // The sample that would bring the count to DEBOUNCE_CYCLES flips
          // the level instead, so the counter never holds that value.
          if (cnt_q == c_DBW'(DEBOUNCE_CYCLES - 1)) begin
            deb_q <= ~deb_q;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end

    assign w_press[gi] = deb_q & ~deb_prev_q;
  end

  // --------------------------------------------------------------------------
  // Request arbitration and queue
  // --------------------------------------------------------------------------
  logic [1:0]      direction_q, direction_d;
  logic [1:0]      mem_q [QUEUE_DEPTH];
  logic [1:0]      mem_d [QUEUE_DEPTH];
  logic [c_CW-1:0] count_q, count_d;
  logic            queue_full_q;
  logic            turn_applied_q;
  logic            turn_rejected_q;

  logic            w_req_valid;
  logic [1:0]      w_req;
  logic [1:0]      w_ref;
  logic            w_pop;
  logic            w_push;
  logic            w_reject;
  logic [c_CW-1:0] w_wr_idx;

  always_comb begin
    w_req_valid = |w_press;
    w_req       = 2'b00;
    if      (w_press[0]) w_req = 2'b00;
    else if (w_press[1]) w_req = 2'b01;
    else if (w_press[2]) w_req = 2'b10;
    else if (w_press[3]) w_req = 2'b11;
  end

  always_comb begin
    // Reference heading is the newest pending turn, or the live heading.
    w_ref = direction_q;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (count_q == c_CW'(i + 1)) w_ref = mem_q[i];
    end

    w_pop = move_tick && (count_q != '0);

    // Same axis (bit 1) means either a duplicate or a reversal; both rejected.
    // A full queue still accepts when the same edge pops an entry.
    w_push   = w_req_valid && (w_req[1] != w_ref[1]) && (!queue_full_q || w_pop);
    w_reject = w_req_valid && !w_push;

    // mem_q[0] is always the oldest entry; a pop shifts everything down.
    mem_d = mem_q;
    if (w_pop) begin
      for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i + 1];
      end
    end

    w_wr_idx = w_pop ? (count_q - 1'b1) : count_q;
    if (w_push) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (c_CW'(i) == w_wr_idx) mem_d[i] = w_req;
      end
    end

    count_d = count_q;
    if (w_push && !w_pop)      count_d = count_q + 1'b1;
    else if (!w_push && w_pop) count_d = count_q - 1'b1;

    // No bypass: only an entry already queued before this edge can be popped.
    direction_d = w_pop ? mem_q[0] : direction_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      direction_q     <= INIT_DIR;
      mem_q           <= '{default: 2'b00};
      count_q         <= '0;
      queue_full_q    <= 1'b0;
      turn_applied_q  <= 1'b0;
      turn_rejected_q <= 1'b0;
    end else begin
      direction_q     <= direction_d;
      mem_q           <= mem_d;
      count_q         <= count_d;
      queue_full_q    <= (count_d == c_CW'(QUEUE_DEPTH));
      turn_applied_q  <= w_pop;
      turn_rejected_q <= w_reject;
    end
  end

  assign direction     = direction_q;
  assign queue_count   = count_q;
  assign queue_full    = queue_full_q;
  assign turn_applied  = turn_applied_q;
  assign turn_rejected = turn_rejected_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_dir_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_dir_queue
// Purpose  : Directed self-checking bench for snake_dir_queue with default
//            parameters (DEBOUNCE_CYCLES=4, QUEUE_DEPTH=2, INIT_DIR=UP).
//            Inputs change and outputs are sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_dir_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       up, down, left, right;
  logic       move_tick;
  logic [1:0] direction;
  logic [1:0] queue_count;
  logic       queue_full;
  logic       turn_applied;
  logic       turn_rejected;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  snake_dir_queue #(
    .DEBOUNCE_CYCLES(4),
    .QUEUE_DEPTH    (2),
    .INIT_DIR       (2'b00)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .up           (up),
    .down         (down),
    .left         (left),
    .right        (right),
    .move_tick    (move_tick),
    .direction    (direction),
    .queue_count  (queue_count),
    .queue_full   (queue_full),
    .turn_applied (turn_applied),
    .turn_rejected(turn_rejected)
  );

  // Stimulus helper: drive {up,down,left,right}, hold for 'hold' falling
  // edges, observe 'total' falling edges and tally the output pulses.
  task automatic press_watch(input logic [3:0] btns, input int hold, input int total,
                             output int rej, output int app, output int first_rej);
    rej = 0; app = 0; first_rej = 0;
    {up, down, left, right} = btns;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      if (turn_rejected) begin
        rej++;
        if (first_rej == 0) first_rej = k;
      end
      if (turn_applied) app++;
      if (k == hold) {up, down, left, right} = 4'b0000;
    end
  endtask

  task automatic do_tick();
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; move_tick = 1'b0;
    {up, down, left, right} = 4'b0000;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n_cmp++; if (direction !== 2'b00) begin n_err++; $display("FAIL reset_dir: got %0d want 0", direction); end
    n_cmp++; if (queue_count !== 2'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", queue_count); end
    n_cmp++; if (queue_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %0b want 0", queue_full); end
    n_cmp++; if ({turn_applied, turn_rejected} !== 2'b00) begin n_err++; $display("FAIL reset_pulses: got %b want 00", {turn_applied, turn_rejected}); end
    @(negedge clk);
    n_cmp++; if (queue_count !== 2'd0 || direction !== 2'b00) begin n_err++; $display("FAIL reset_idle: got cnt %0d dir %0d want 0 0", queue_count, direction); end
  endtask

  task automatic test_reject_reverse();
    int rej, app, first;
    press_watch(4'b0100, 10, 18, rej, app, first);   // down while heading UP
    n_cmp++; if (rej !== 1) begin n_err++; $display("FAIL rev_rej_count: got %0d want 1", rej); end
    n_cmp++; if (first !== 7) begin n_err++; $display("FAIL rev_rej_latency: got %0d want 7", first); end
    n_cmp++; if (direction !== 2'b00 || queue_count !== 2'd0) begin n_err++; $display("FAIL rev_state: got dir %0d cnt %0d want 0 0", direction, queue_count); end
    press_watch(4'b0001, 3, 12, rej, app, first);    // short right pulse
    n_cmp++; if (rej !== 0) begin n_err++; $display("FAIL short_pulse_rej: got %0d want 0", rej); end
    n_cmp++; if (queue_count !== 2'd0) begin n_err++; $display("FAIL short_pulse_count: got %0d want 0", queue_count); end
  endtask

  task automatic fill_right_down(input string tag);
    int rej, app, first;
    press_watch(4'b0001, 8, 16, rej, app, first);
    press_watch(4'b0100, 8, 16, rej, app, first);
    n_cmp++; if (queue_count !== 2'd2 || queue_full !== 1'b1) begin n_err++; $display("FAIL %s_fill: got cnt %0d full %0b want 2 1", tag, queue_count, queue_full); end
  endtask

  task automatic test_queue_fill();
    fill_right_down("q");
    n_cmp++; if (direction !== 2'b00) begin n_err++; $display("FAIL q_dir_hold: got %0d want 0", direction); end
    do_tick();
    n_cmp++; if (direction !== 2'b11 || turn_applied !== 1'b1) begin n_err++; $display("FAIL q_tick1: got dir %0d app %0b want 3 1", direction, turn_applied); end
    n_cmp++; if (queue_count !== 2'd1 || queue_full !== 1'b0) begin n_err++; $display("FAIL q_tick1_count: got cnt %0d full %0b want 1 0", queue_count, queue_full); end
    @(negedge clk);
    n_cmp++; if (turn_applied !== 1'b0) begin n_err++; $display("FAIL q_app_width: got %0b want 0", turn_applied); end
    do_tick();
    n_cmp++; if (direction !== 2'b01 || queue_count !== 2'd0 || turn_applied !== 1'b1) begin n_err++; $display("FAIL q_tick2: got dir %0d cnt %0d app %0b want 1 0 1", direction, queue_count, turn_applied); end
    @(negedge clk);
    do_tick();
    n_cmp++; if (direction !== 2'b01 || queue_count !== 2'd0 || turn_applied !== 1'b0) begin n_err++; $display("FAIL q_tick_empty: got dir %0d cnt %0d app %0b want 1 0 0", direction, queue_count, turn_applied); end
  endtask

  task automatic test_full_reject();
    int rej, app, first, rej2;
    reset = 1'b0; @(negedge clk); reset = 1'b1;
    fill_right_down("f");
    press_watch(4'b0010, 8, 16, rej, app, first);    // left, queue full, no tick
    n_cmp++; if (rej !== 1 || queue_count !== 2'd2) begin n_err++; $display("FAIL full_reject: got rej %0d cnt %0d want 1 2", rej, queue_count); end
    // Left again, move_tick lined up with the press event cycle.
    rej2 = 0;
    left = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (turn_rejected) rej2++;
      if (k == 7) begin
        move_tick = 1'b0;
        n_cmp++; if (direction !== 2'b11 || queue_count !== 2'd2 || queue_full !== 1'b1 || turn_applied !== 1'b1) begin
          n_err++; $display("FAIL full_pushpop: got dir %0d cnt %0d full %0b app %0b want 3 2 1 1", direction, queue_count, queue_full, turn_applied);
        end
      end
      if (k == 6) move_tick = 1'b1;
      if (k == 8) left = 1'b0;
    end
    n_cmp++; if (rej2 !== 0) begin n_err++; $display("FAIL full_pushpop_rej: got %0d want 0", rej2); end
    do_tick();
    n_cmp++; if (direction !== 2'b01 || queue_count !== 2'd1) begin n_err++; $display("FAIL full_pop_down: got dir %0d cnt %0d want 1 1", direction, queue_count); end
    do_tick();
    n_cmp++; if (direction !== 2'b10 || queue_count !== 2'd0) begin n_err++; $display("FAIL full_pop_left: got dir %0d cnt %0d want 2 0", direction, queue_count); end
  endtask

  task automatic test_priority();
    int rej, app, first;
    press_watch(4'b1001, 8, 16, rej, app, first);    // up + right together, heading LEFT
    n_cmp++; if (rej !== 0 || queue_count !== 2'd1) begin n_err++; $display("FAIL prio_push: got rej %0d cnt %0d want 0 1", rej, queue_count); end
    do_tick();
    n_cmp++; if (direction !== 2'b00) begin n_err++; $display("FAIL prio_dir: got %0d want 0", direction); end
  endtask

  task automatic test_reset_flush();
    fill_right_down("r");
    reset = 1'b0; @(negedge clk); reset = 1'b1;
    n_cmp++; if (direction !== 2'b00 || queue_count !== 2'd0 || queue_full !== 1'b0) begin n_err++; $display("FAIL flush_state: got dir %0d cnt %0d full %0b want 0 0 0", direction, queue_count, queue_full); end
    @(negedge clk);
    do_tick();
    n_cmp++; if (direction !== 2'b00 || turn_applied !== 1'b0) begin n_err++; $display("FAIL flush_tick: got dir %0d app %0b want 0 0", direction, turn_applied); end
  endtask

  task automatic test_hold_through_reset();
    right = 1'b1;
    reset = 1'b0; repeat (3) @(negedge clk); reset = 1'b1;
    repeat (14) @(negedge clk);
    n_cmp++; if (queue_count !== 2'd1) begin n_err++; $display("FAIL held_press: got cnt %0d want 1", queue_count); end
    repeat (10) @(negedge clk);
    n_cmp++; if (queue_count !== 2'd1) begin n_err++; $display("FAIL held_single: got cnt %0d want 1", queue_count); end
    right = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_reject_reverse();
    test_queue_fill();
    test_full_reject();
    test_priority();
    test_reset_flush();
    test_hold_through_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
